rgb_pwm_ctrl: RTL and testbench

RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

---
 rtl/rgb_pwm_pkg.sv | 15 +
 rtl/rgb_pwm_chan.sv | 115 +++++++++++
 rtl/rgb_pwm_ctrl.sv | 75 +++++++
 tb/tb_rgb_pwm_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared definitions for the RGB PWM controller.
//   MODE_W  - width of the per-channel mode field
//   mode_e  - channel operating modes (OFF / STEADY / BLINK / BREATHE)
package rgb_pwm_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

endpackage

// File: rtl/rgb_pwm_chan.sv
// rgb_pwm_chan: one LED channel. Holds the shadow {mode,duty} written by the
// host, the active copy loaded at frame boundaries, blink/breathe state and
// the registered PWM comparator.
//   hw_clk, rst_n  - clock, async active-low reset
//   wr_en          - accepted write targeting this channel
//   wr_mode/duty   - write payload (goes to shadow)
//   frame_end      - PWM counter wrap pulse from the shared timebase
//   pwm_cnt        - shared PWM counter
//   pwm_out        - registered PWM output
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic             hw_clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  mode_e            wr_mode,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic             frame_end,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             pwm_out
);

  localparam int unsigned        BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0]    BC_LAST = BC_W'(BLINK_FRAMES - 1);

  mode_e            sh_mode, act_mode;
  logic [PWM_W-1:0] sh_duty, act_duty;
  logic             blink_ph;
  logic [BC_W-1:0]  blink_cnt;
  logic [PWM_W-1:0] ramp, ramp_step, ramp_clamp, level;
  logic             ramp_up, ramp_up_n;

  // Next breathe position: move one step, reversing at 0 and at duty.
  // A reversal also takes the first step in the new direction so the
  // peak and trough are each held for exactly one frame.
  always_comb begin
    ramp_step = ramp;
    ramp_up_n = ramp_up;
    if (ramp_up) begin
      if (ramp >= act_duty) begin
        ramp_up_n = 1'b0;
        if (ramp != '0) ramp_step = ramp - 1'b1;
      end else begin
        ramp_step = ramp + 1'b1;
      end
    end else begin
      if (ramp == '0) begin
        ramp_up_n = 1'b1;
        if (act_duty != '0) ramp_step = ramp + 1'b1;
      end else begin
        ramp_step = ramp - 1'b1;
      end
    end
    // Same-mode duty change: never let the ramp sit above the new peak.
    ramp_clamp = (ramp_step > sh_duty) ? sh_duty : ramp_step;
  end

  always_comb begin
    case (act_mode)
      MODE_STEADY:  level = act_duty;
      MODE_BLINK:   level = blink_ph ? act_duty : '0;
      MODE_BREATHE: level = ramp;
      default:      level = '0;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mode   <= MODE_OFF;
      sh_duty   <= '0;
      act_mode  <= MODE_OFF;
      act_duty  <= '0;
      blink_ph  <= 1'b0;
      blink_cnt <= '0;
      ramp      <= '0;
      ramp_up   <= 1'b0;
      pwm_out   <= 1'b0;
    end else begin
      // Active takes the pre-write shadow; a write in this same cycle
      // lands in the shadow and waits for the next frame boundary.
      if (frame_end) begin
        act_mode <= sh_mode;
        act_duty <= sh_duty;
        if (sh_mode != act_mode) begin
          blink_ph  <= 1'b1;
          blink_cnt <= '0;
          ramp      <= '0;
          ramp_up   <= 1'b1;
        end else begin
          if (act_mode == MODE_BLINK) begin
            if (blink_cnt == BC_LAST) begin
              blink_cnt <= '0;
              blink_ph  <= ~blink_ph;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
          if (act_mode == MODE_BREATHE) begin
            ramp    <= ramp_clamp;
            ramp_up <= ramp_up_n;
          end
        end
      end
      if (wr_en) begin
        sh_mode <= wr_mode;
        sh_duty <= wr_duty;
      end
      pwm_out <= (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: multi-channel LED PWM controller with a shared prescaler and
// PWM counter, and per-channel OFF / STEADY / BLINK / BREATHE modes.
//   hw_clk, rst_n - clock, async active-low reset
//   cfg_valid/cfg_ready - configuration write handshake
//   cfg_ch, cfg_mode, cfg_duty - write target channel and payload
//   cfg_err   - one-cycle pulse after a write to a nonexistent channel
//   pwm_out   - per-channel PWM outputs
//   frame_end - pulse in the cycle of the PWM counter wrap
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned PRESC_DIV    = 47,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_end
);

  localparam int unsigned     PR_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PRESC_DIV - 1);

  logic [PR_W-1:0]   presc_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              tick;
  logic              cfg_acc;
  logic [NUM_CH-1:0] ch_wr;

  assign tick      = (presc_cnt == PR_LAST);
  assign frame_end = tick && (pwm_cnt == '1);
  assign cfg_acc   = cfg_valid && cfg_ready;

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      cfg_err   <= cfg_acc && (32'(cfg_ch) >= NUM_CH);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = cfg_acc && (32'(cfg_ch) == i);

    rgb_pwm_chan #(
      .PWM_W        (PWM_W),
      .BLINK_FRAMES (BLINK_FRAMES)
    ) u_chan (
      .hw_clk    (hw_clk),
      .rst_n     (rst_n),
      .wr_en     (ch_wr[i]),
      .wr_mode   (mode_e'(cfg_mode)),
      .wr_duty   (cfg_duty),
      .frame_end (frame_end),
      .pwm_cnt   (pwm_cnt),
      .pwm_out   (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
module tb_rgb_pwm_ctrl;
  localparam int NUM_CH = 3;
  localparam int PWM_W  = 4;
  localparam int PRESC  = 2;
  localparam int BF     = 2;
  localparam int TICKS  = 1 << PWM_W;
  localparam int FRAME  = TICKS * PRESC;

  logic        hw_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  cfg_duty = '0;
  logic        cfg_err;
  logic [2:0]  pwm_out;
  logic        frame_end;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level integer state per channel.
  int cyc;
  int sh_mode[NUM_CH], sh_duty[NUM_CH], ac_mode[NUM_CH], ac_duty[NUM_CH];
  int phase[NUM_CH], bcnt[NUM_CH], ramp[NUM_CH], up[NUM_CH];
  logic [2:0] exp_pwm;
  logic exp_fe, exp_err, exp_ready;

  rgb_pwm_ctrl #(
    .NUM_CH       (NUM_CH),
    .PWM_W        (PWM_W),
    .PRESC_DIV    (PRESC),
    .BLINK_FRAMES (BF)
  ) dut (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .pwm_out   (pwm_out),
    .frame_end (frame_end)
  );

  always #5 hw_clk = ~hw_clk;

  function automatic int lvl(int i);
    case (ac_mode[i])
      1: return ac_duty[i];
      2: return (phase[i] != 0) ? ac_duty[i] : 0;
      3: return ramp[i];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      sh_mode[i] = 0; sh_duty[i] = 0; ac_mode[i] = 0; ac_duty[i] = 0;
      phase[i] = 0; bcnt[i] = 0; ramp[i] = 0; up[i] = 0;
    end
    cyc = 0; exp_pwm = '0; exp_fe = 1'b0; exp_err = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic model_frame();
    for (int i = 0; i < NUM_CH; i++) begin
      if (sh_mode[i] != ac_mode[i]) begin
        phase[i] = 1; bcnt[i] = 0; ramp[i] = 0; up[i] = 1;
      end else if (ac_mode[i] == 2) begin
        bcnt[i]++;
        if (bcnt[i] == BF) begin bcnt[i] = 0; phase[i] = 1 - phase[i]; end
      end else if (ac_mode[i] == 3) begin
        if (up[i] != 0) begin
          if (ramp[i] < ac_duty[i]) ramp[i]++;
          else begin up[i] = 0; if (ramp[i] > 0) ramp[i]--; end
        end else begin
          if (ramp[i] > 0) ramp[i]--;
          else begin up[i] = 1; if (ramp[i] < ac_duty[i]) ramp[i]++; end
        end
        if (ramp[i] > sh_duty[i]) ramp[i] = sh_duty[i];
      end
      ac_mode[i] = sh_mode[i];
      ac_duty[i] = sh_duty[i];
    end
  endtask

  // Drive one cycle of inputs, advance the model, land #1 after the edge.
  task automatic step(input logic wr, input int ch, input int mode, input int duty);
    cfg_valid = wr; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_duty = 4'(duty);
    for (int i = 0; i < NUM_CH; i++)
      exp_pwm[i] = (((cyc / PRESC) % TICKS) < lvl(i));
    exp_err   = wr && (ch >= NUM_CH);
    exp_ready = 1'b1;
    exp_fe    = (((cyc + 1) % FRAME) == FRAME - 1);
    if ((cyc % FRAME) == FRAME - 1) model_frame();
    if (wr && ch < NUM_CH) begin sh_mode[ch] = mode; sh_duty[ch] = duty; end
    @(posedge hw_clk); #1;
    cfg_valid = 1'b0;
    cyc++;
  endtask

  task automatic run_to_fe();
    while ((cyc % FRAME) != FRAME - 1) step(1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int fe_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge hw_clk);
    #1;
    checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL reset_pwm got=%b exp=000", pwm_out); end
    checks++; if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", frame_end); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 0, 0, 0);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", cfg_ready); end
    fe_seen = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL idle_pwm cyc=%0d got=%b exp=000", cyc, pwm_out); end
      checks++; if (frame_end !== exp_fe) begin errors++; $display("FAIL idle_fe cyc=%0d got=%b exp=%b", cyc, frame_end, exp_fe); end
      if (frame_end === 1'b1) fe_seen++;
      step(1'b0, 0, 0, 0);
    end
    checks++; if (fe_seen != 2) begin errors++; $display("FAIL idle_fe_count got=%0d exp=2", fe_seen); end
  endtask

  task automatic test_steady();
    int hi;
    step(1'b1, 0, 1, 4);
    run_to_fe();
    step(1'b0, 0, 0, 0);
    hi = 0;
    for (int k = 0; k < FRAME; k++) begin
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL steady_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
      checks++; if (pwm_out[2:1] !== 2'b00) begin errors++; $display("FAIL steady_others cyc=%0d got=%b exp=00", cyc, pwm_out[2:1]); end
      hi += int'(pwm_out[0]);
      step(1'b0, 0, 0, 0);
    end
    checks++; if (hi != 8) begin errors++; $display("FAIL steady_count got=%0d exp=8", hi); end
  endtask

  task automatic test_blink();
    int want[5] = '{30, 30, 0, 0, 30};
    int hi;
    step(1'b1, 1, 2, 15);
    run_to_fe();
    step(1'b0, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
        checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL blink_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
        hi += int'(pwm_out[1]);
        step(1'b0, 0, 0, 0);
      end
      checks++; if (hi != want[f]) begin errors++; $display("FAIL blink_frame%0d got=%0d exp=%0d", f, hi, want[f]); end
    end
  endtask

  task automatic test_breathe();
    int want[9] = '{0, 2, 4, 6, 4, 2, 0, 2, 4};
    int hi;
    step(1'b1, 2, 3, 3);
    run_to_fe();
    step(1'b0, 0, 0, 0);
    for (int f = 0; f < 9; f++) begin
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
        checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL breathe_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
        hi += int'(pwm_out[2]);
        step(1'b0, 0, 0, 0);
      end
      checks++; if (hi != want[f]) begin errors++; $display("FAIL breathe_frame%0d got=%0d exp=%0d", f, hi, want[f]); end
    end
  endtask

  task automatic test_err();
    step(1'b1, 3, 1, 15);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
    step(1'b0, 0, 0, 0);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
    for (int k = 0; k < FRAME + 8; k++) begin
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL err_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
      step(1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_frame_edge_write();
    int want[2] = '{8, 20};
    int hi;
    run_to_fe();
    checks++; if (frame_end !== 1'b1) begin errors++; $display("FAIL edge_fe got=%b exp=1", frame_end); end
    step(1'b1, 0, 1, 10);
    for (int f = 0; f < 2; f++) begin
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
        checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL edge_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
        hi += int'(pwm_out[0]);
        step(1'b0, 0, 0, 0);
      end
      checks++; if (hi != want[f]) begin errors++; $display("FAIL edge_frame%0d got=%0d exp=%0d", f, hi, want[f]); end
    end
  endtask

  task automatic test_random();
    logic wr;
    for (int k = 0; k < 800; k++) begin
      checks++; if (pwm_out !== exp_pwm) begin errors++; $display("FAIL rand_pwm cyc=%0d got=%b exp=%b", cyc, pwm_out, exp_pwm); end
      checks++; if (frame_end !== exp_fe) begin errors++; $display("FAIL rand_fe cyc=%0d got=%b exp=%b", cyc, frame_end, exp_fe); end
      checks++; if (cfg_err !== exp_err) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, cfg_err, exp_err); end
      checks++; if (cfg_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, exp_ready); end
      wr = ($urandom_range(0, 5) == 0);
      step(wr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < NUM_CH; c++) step(1'b1, c, 1, 15);
    run_to_fe();
    for (int k = 0; k < 11; k++) step(1'b0, 0, 0, 0);
    checks++; if (pwm_out !== 3'b111) begin errors++; $display("FAIL mid_pre got=%b exp=111", pwm_out); end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_duty = 4'd15;
    rst_n = 1'b0;
    #1;
    checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL mid_async_pwm got=%b exp=000", pwm_out); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_async_ready got=%b exp=0", cfg_ready); end
    repeat (3) @(posedge hw_clk);
    #1;
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      checks++; if (pwm_out !== 3'b000) begin errors++; $display("FAIL mid_off cyc=%0d got=%b exp=000", cyc, pwm_out); end
      checks++; if (frame_end !== exp_fe) begin errors++; $display("FAIL mid_fe cyc=%0d got=%b exp=%b", cyc, frame_end, exp_fe); end
      step(1'b0, 0, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_steady();
    test_blink();
    test_breathe();
    test_err();
    test_frame_edge_write();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
